// File: rtl/stat_minmax_if.sv
// Sample stream, session control and result bus for stat_minmax.
interface stat_minmax_if;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] min_out;
  logic [3:0] max_out;
  logic [7:0] sum_out;
  logic [4:0] count_out;

  // Driver side: opens sessions and offers samples.
  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, busy, done, min_out, max_out, sum_out, count_out
  );

  // Block side: collects samples and reports statistics.
  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, busy, done, min_out, max_out, sum_out, count_out
  );
endinterface

// File: rtl/stat_minmax.sv
// Per-session min/max/sum/count of a stream of 4-bit unsigned samples.
module stat_minmax #(
  parameter int unsigned MAX_N = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  stat_minmax_if.slave  bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_e;

  state_e          state_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   min_q;
  logic [DW-1:0]   max_q;
  logic [SW-1:0]   sum_q;
  logic [CW-1:0]   count_q;

  logic            accept_c;
  logic            first_c;
  logic            final_c;
  logic [CW-1:0]   count_inc_c;

  // Sample handshake and session-termination decode.
  assign accept_c    = in_ready_q && bus.in_valid;
  assign first_c     = (count_q == CW'(0));
  assign count_inc_c = count_q + CW'(1);
  assign final_c     = bus.in_last || (count_inc_c == CW'(MAX_N));

  // Session FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q    <= COLLECT;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            sum_q      <= '0;
            count_q    <= '0;
          end
        end
        COLLECT: begin
          if (accept_c) begin
            // First sample seeds both extremes; equal values leave them alone.
            if (first_c || (bus.in_data < min_q)) min_q <= bus.in_data;
            if (first_c || (bus.in_data > max_q)) max_q <= bus.in_data;
            sum_q   <= sum_q + SW'(bus.in_data);
            count_q <= count_inc_c;
            if (final_c) begin
              state_q    <= REPORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        REPORT: begin
          // start is intentionally dropped here.
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Drive the bus from the registered state.
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.min_out   = min_q;
  assign bus.max_out   = max_q;
  assign bus.sum_out   = sum_q;
  assign bus.count_out = count_q;

endmodule

// File: tb/tb_stat_minmax.sv
// Directed scoreboard bench for stat_minmax.
module tb_stat_minmax;

  typedef struct {
    logic [3:0] mn;
    logic [3:0] mx;
    logic [7:0] sm;
    logic [4:0] ct;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  res_t sb[$];
  res_t held;

  stat_minmax_if bus ();

  stat_minmax #(.MAX_N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] mn, input logic [3:0] mx,
                          input logic [7:0] sm, input logic [4:0] ct);
    res_t r;
    r.mn = mn; r.mx = mx; r.sm = sm; r.ct = ct;
    sb.push_back(r);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offer one sample for one cycle; in_valid left high for the caller to drop.
  task automatic send(input logic [3:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called at the negedge right after the final sample's accepting edge.
  task automatic expect_done(input string tag);
    int   lat;
    res_t e;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_latency"}, 32'(lat), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      held = e;
      chk({tag, "_min"},      32'(bus.min_out),   32'(e.mn));
      chk({tag, "_max"},      32'(bus.max_out),   32'(e.mx));
      chk({tag, "_sum"},      32'(bus.sum_out),   32'(e.sm));
      chk({tag, "_count"},    32'(bus.count_out), 32'(e.ct));
      chk({tag, "_busy_rpt"}, 32'(bus.busy),      32'd0);
      chk({tag, "_rdy_rpt"},  32'(bus.in_ready),  32'd0);
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_min"},   32'(bus.min_out),   32'(held.mn));
    chk({tag, "_max"},   32'(bus.max_out),   32'(held.mx));
    chk({tag, "_sum"},   32'(bus.sum_out),   32'(held.sm));
    chk({tag, "_count"}, 32'(bus.count_out), 32'(held.ct));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"},   32'(bus.in_ready),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
    chk({tag, "_min"},   32'(bus.min_out),   32'd0);
    chk({tag, "_max"},   32'(bus.max_out),   32'd0);
    chk({tag, "_sum"},   32'(bus.sum_out),   32'd0);
    chk({tag, "_count"}, 32'(bus.count_out), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    bus.in_last  = 1'b0;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Four back-to-back samples
    push_exp(4'd2, 4'd9, 8'd18, 5'd4);
    do_start();
    chk("s1_busy_open", 32'(bus.busy), 32'd1);
    chk("s1_rdy_open",  32'(bus.in_ready), 32'd1);
    send(4'd5, 1'b0);
    send(4'd2, 1'b0);
    send(4'd9, 1'b0);
    send(4'd2, 1'b1);
    idle_in();
    expect_done("s1");
    @(negedge clk);
    chk("s1_done_one_cycle", 32'(bus.done), 32'd0);
    check_held("s1_hold");

    // New start clears sum/count, keeps min/max until first sample
    push_exp(4'd7, 4'd7, 8'd7, 5'd1);
    do_start();
    chk("s2_sum_clr",   32'(bus.sum_out),   32'd0);
    chk("s2_count_clr", 32'(bus.count_out), 32'd0);
    chk("s2_min_kept",  32'(bus.min_out),   32'd2);
    chk("s2_max_kept",  32'(bus.max_out),   32'd9);
    send(4'd7, 1'b1);
    idle_in();
    expect_done("s2");

    // Sixteen samples of 15 with no in_last: auto-terminate
    push_exp(4'd15, 4'd15, 8'd240, 5'd16);
    do_start();
    for (int i = 0; i < 16; i++) send(4'd15, 1'b0);
    expect_done("s3");
    @(negedge clk);
    @(negedge clk);
    idle_in();
    chk("s3_rdy_after",   32'(bus.in_ready),  32'd0);
    chk("s3_count_after", 32'(bus.count_out), 32'd16);
    chk("s3_sum_after",   32'(bus.sum_out),   32'd240);

    // Gapped samples, in_valid in IDLE, start mid-COLLECT and in REPORT
    push_exp(4'd2, 4'd9, 8'd18, 5'd4);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd0;
    @(negedge clk);
    idle_in();
    do_start();
    send(4'd5, 1'b0);
    idle_in();
    @(negedge clk);
    bus.start = 1'b1;
    send(4'd2, 1'b0);
    bus.start = 1'b0;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    chk("s4_busy_mid", 32'(bus.busy), 32'd1);
    send(4'd9, 1'b0);
    idle_in();
    @(negedge clk);
    send(4'd2, 1'b1);
    idle_in();
    expect_done("s4");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("s4_rpt_start_dropped", 32'(bus.busy), 32'd0);
    check_held("s4_hold");

    // Reset mid-session
    do_start();
    send(4'd3, 1'b0);
    send(4'd12, 1'b0);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    check_zero("s5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_no_done", 32'(bus.done), 32'd0);
    end
    chk("s5_busy_idle", 32'(bus.busy), 32'd0);

    // Extremes 0 and 15, then hold through idle cycles
    push_exp(4'd0, 4'd15, 8'd15, 5'd2);
    do_start();
    send(4'd0, 1'b0);
    send(4'd15, 1'b1);
    idle_in();
    expect_done("s6");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_held("s6_hold");
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stat_minmax.md
STAT_MINMAX -- requirements
Module: stat_minmax

Interface
REQ-001 SHALL have parameter MAX_N, default 16, meaning the maximum number of samples per session (legal 2..16).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a single-cycle request to open a new session.
REQ-005 SHALL have port in_valid, input, 1, meaning a sample is offered on in_data.
REQ-006 SHALL have port in_data, input, 4, the unsigned sample value.
REQ-007 SHALL have port in_last, input, 1, marking the offered sample as the session's final sample.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-009 SHALL have port busy, output, 1, high while a session is open.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when results become valid.
REQ-011 SHALL have port min_out, output, 4, the smallest accepted sample.
REQ-012 SHALL have port max_out, output, 4, the largest accepted sample.
REQ-013 SHALL have port sum_out, output, 8, the unsigned sum of accepted samples.
REQ-014 SHALL have port count_out, output, 5, the number of accepted samples.

Function
REQ-015 SHALL implement three states: IDLE, COLLECT and REPORT.
REQ-016 SHALL move IDLE->COLLECT on start=1, clearing count and sum, and leaving min/max undefined-but-overwritten by the first sample.
REQ-017 SHALL drive in_ready=1 only in COLLECT, and busy=1 only in COLLECT.
REQ-018 SHALL accept a sample on a cycle with in_valid=1 and in_ready=1; in_valid without in_ready has no effect.
REQ-019 SHALL, on the first accepted sample, load min and max with in_data.
REQ-020 SHALL, on later samples, use 4-bit unsigned magnitude compares: in_data<min replaces min, in_data>max replaces max, and equal values change neither.
REQ-021 SHALL add each accepted sample, zero-extended, to sum and increment count by 1 in the same cycle; no overflow is possible within MAX_N<=16.
REQ-022 SHALL move COLLECT->REPORT on the cycle after accepting a sample that has in_last=1 or that makes count equal MAX_N, whichever occurs first.
REQ-023 SHALL assert done for exactly the one cycle spent in REPORT, then return to IDLE.
REQ-024 SHALL hold min_out, max_out, sum_out and count_out stable from the done cycle until the next accepted start.
REQ-025 SHALL ignore start in COLLECT and REPORT; start asserted in the REPORT cycle is dropped.
REQ-026 SHALL, on start in IDLE, clear sum_out and count_out on the next edge; min_out and max_out update only with the first new sample.
REQ-027 SHALL have a done-assertion latency of exactly 1 cycle after the final sample is accepted.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE and in_ready=0, busy=0, done=0, min_out=0, max_out=0, sum_out=0 and count_out=0, independent of clk.
REQ-029 SHALL abandon any open session on reset, with no done pulse on release.
REQ-030 SHALL begin responding to start on the first rising clk edge after rst_n deasserts.

Verification
REQ-031 Bench SHALL cover: start, then samples 5,2,9,2(last) back-to-back -> done 1 cycle after last; min=2, max=9, sum=18, count=4.
REQ-032 Bench SHALL cover: a single sample 7 with in_last=1 -> min=7, max=7, sum=7, count=1.
REQ-033 Bench SHALL cover: 16 samples of 15 with no in_last (MAX_N=16) -> auto-terminate after the 16th; sum=240, count=16, max=15, min=15; in_ready=0 afterward.
REQ-034 Bench SHALL cover: in_valid toggling with gaps, plus start pulsed mid-COLLECT -> start is ignored and results equal those of the gap-free case.
REQ-035 Bench SHALL cover: rst_n pulled low after 2 samples -> all outputs read 0 immediately; no done; a new session then behaves normally.
REQ-036 Bench SHALL cover: samples 0,15 (last) -> min=0, max=15, sum=15, count=2; values stay held through 5 idle cycles.
